adder_arbiter: RTL

- Shares one `adder` instance (INPUT_WIDTH-bit unsigned ripple-carry, INPUT_WIDTH+1-bit sum) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter picks one pair per cycle and the adder computes the sum.
- The sum goes into a one-entry output register, tagged with the requester index, and drains through a valid/ready response port.

---
 rtl/adder_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one ripple-carry adder among NUM_REQ requesters.
// A round-robin arbiter picks one operand pair per cycle; the sum is
// captured in a one-entry response register tagged with the requester index.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_a      operand A, requester i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   req_b      operand B, same packing
//   req_ready  one-hot grant (transfer on req_valid & req_ready)
//   rsp_valid  response register holds a result
//   rsp_ready  consumer accepts the response
//   rsp_sum    registered a+b, MSB is carry-out
//   rsp_id     index of the requester that produced rsp_sum

// adder: unsigned ripple-carry adder, WIDTH-bit operands, WIDTH+1-bit sum.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign sum_o[WIDTH] = carry[WIDTH];

endmodule

module adder_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int INPUT_WIDTH = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [INPUT_WIDTH:0]           rsp_sum,
  output logic [ID_W-1:0]                rsp_id
);

  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   rsp_valid_q;
  logic [INPUT_WIDTH:0]   rsp_sum_q;
  logic [ID_W-1:0]        rsp_id_q;

  logic                   can_accept;
  logic                   found;
  logic [ID_W-1:0]        win;
  int                     idx;
  logic [INPUT_WIDTH-1:0] a_sel, b_sel;
  logic [INPUT_WIDTH:0]   sum;
  logic                   accept;

  assign can_accept = ~rsp_valid_q | rsp_ready;

  // Rotating priority search: first valid requester at or after ptr_q.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign accept = found & can_accept;

  // Gating with rst_n keeps grants low for the whole reset window.
  always_comb begin
    req_ready = '0;
    if (rst_n && accept) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        a_sel = req_a[i*INPUT_WIDTH +: INPUT_WIDTH];
        b_sel = req_b[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  end

  adder #(.WIDTH(INPUT_WIDTH)) u_adder (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .sum_o (sum)
  );

  // Explicit wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_sum_q   <= sum;
        rsp_id_q    <= win;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

endmodule
